mux_logic_pipe: RTL and testbench

MUX_LOGIC_PIPE -- requirements
Module: mux_logic_pipe

---
 rtl/mux_logic_pkg.sv | 37 +++
 rtl/mux_logic_pipe.sv | 124 ++++++++++++
 tb/tb_mux_logic_pipe.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mux_logic_pkg.sv
// ---------------------------------------------------------------------------
// mux_logic_pkg
//   Shared definitions for the mux_logic_pipe block.
//   - OP_W     : width of the operation code
//   - op_e     : operation code encoding
//   - op_apply : bitwise operation evaluated on 64-bit operands; callers
//                zero-extend their operands and keep the low WIDTH bits.
// ---------------------------------------------------------------------------
package mux_logic_pkg;

   localparam int OP_W = 2;

   typedef enum logic [OP_W-1:0] {
      OP_AND  = 2'd0,
      OP_OR   = 2'd1,
      OP_XOR  = 2'd2,
      OP_NAND = 2'd3
   } op_e;

   // Pure bitwise logic: no carries, so evaluating at 64 bits and truncating
   // gives the same low bits as evaluating at any narrower width.
   function automatic logic [63:0] op_apply(input op_e op,
                                            input logic [63:0] x,
                                            input logic [63:0] y);
      logic [63:0] r;
      r = '0;
      case (op)
         OP_AND:  r = x & y;
         OP_OR:   r = x | y;
         OP_XOR:  r = x ^ y;
         OP_NAND: r = ~(x & y);
         default: r = '0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/mux_logic_pipe.sv
// ---------------------------------------------------------------------------
// mux_logic_pipe
//   Two-stage bitwise logic pipeline with an optional accumulator operand.
//   S1 registers the input beat (op, acc_en, a, b); S2 computes
//   op_apply(op, x, b) and registers the result, where x is the accumulator
//   when the beat has acc_en set and a otherwise.
//
//   Ports
//     clk        in   clock, all state on rising edge
//     rst_n      in   asynchronous active-low reset
//     in_valid   in   input beat valid
//     in_ready   out  block can accept an input beat
//     op         in   operation code (op_e)
//     acc_en     in   use accumulator in place of a
//     acc_clr    in   synchronous accumulator clear (wins over an update)
//     a, b       in   operands, WIDTH bits
//     out_valid  out  result valid
//     out_ready  in   downstream accepts the result
//     result     out  registered result, WIDTH bits
//     txn_count  out  number of results accepted downstream (wraps)
//
//   Handshake: a beat transfers on a port in every cycle where its valid and
//   ready are both high. Once valid is raised the source holds the beat
//   unchanged until it transfers. in_ready never looks at in_valid; it is a
//   combinational function of out_ready and pipeline occupancy only.
// ---------------------------------------------------------------------------
module mux_logic_pipe
   import mux_logic_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [OP_W-1:0]   op,
   input  logic              acc_en,
   input  logic              acc_clr,
   input  logic [WIDTH-1:0]  a,
   input  logic [WIDTH-1:0]  b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  result,
   output logic [CNT_W-1:0]  txn_count
);

   // S1 contents
   logic              s1_valid;
   op_e               s1_op;
   logic              s1_acc_en;
   logic [WIDTH-1:0]  s1_a;
   logic [WIDTH-1:0]  s1_b;

   logic [WIDTH-1:0]  acc;

   logic              stall;
   logic              s2_load;
   logic [WIDTH-1:0]  x_opnd;
   logic [WIDTH-1:0]  res_next;

   // S2 is blocked only when it holds a beat the consumer is refusing.
   assign stall    = out_valid && !out_ready;
   assign s2_load  = !stall;
   assign in_ready = !(s1_valid && stall);

   // acc is written on the same edge an acc_en beat moves into S2, so the
   // next S1 beat already sees the updated value without a bubble.
   assign x_opnd   = s1_acc_en ? acc : s1_a;
   assign res_next = WIDTH'(op_apply(s1_op, 64'(x_opnd), 64'(s1_b)));

   // Stage 1 register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid  <= 1'b0;
         s1_op     <= OP_AND;
         s1_acc_en <= 1'b0;
         s1_a      <= '0;
         s1_b      <= '0;
      end else if (in_ready) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_op     <= op_e'(op);
            s1_acc_en <= acc_en;
            s1_a      <= a;
            s1_b      <= b;
         end
      end
   end

   // Stage 2 register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         result    <= '0;
      end else if (s2_load) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            result <= res_next;
         end
      end
   end

   // Accumulator: a clear wins over an update, and also acts while stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
      end else if (acc_clr) begin
         acc <= '0;
      end else if (s2_load && s1_valid && s1_acc_en) begin
         acc <= res_next;
      end
   end

   // Output acceptance counter, wraps naturally at 2^CNT_W.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         txn_count <= '0;
      end else if (out_valid && out_ready) begin
         txn_count <= txn_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_mux_logic_pipe.sv
// ---------------------------------------------------------------------------
// tb_mux_logic_pipe
//   Self-checking bench for mux_logic_pipe (WIDTH=8, CNT_W=16). A queue-based
//   reference model tracks accepted-but-uncomputed beats and computed-but-
//   undelivered results; one negedge process compares the DUT against it each
//   cycle. Directed phases pin the model with literal expectations.
// ---------------------------------------------------------------------------
module tb_mux_logic_pipe;
   import mux_logic_pkg::*;

   localparam int WIDTH = 8;
   localparam int CNT_W = 16;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              in_valid;
   logic              in_ready;
   logic [1:0]        op;
   logic              acc_en;
   logic              acc_clr;
   logic [WIDTH-1:0]  a;
   logic [WIDTH-1:0]  b;
   logic              out_valid;
   logic              out_ready;
   logic [WIDTH-1:0]  result;
   logic [CNT_W-1:0]  txn_count;

   mux_logic_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .acc_en    (acc_en),
      .acc_clr   (acc_clr),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .txn_count (txn_count)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- scoreboard state ----------------
   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [1:0]       op;
      logic             acc_en;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
   } beat_t;

   beat_t             pend_q[$];   // accepted, not yet computed
   logic [WIDTH-1:0]  exp_q[$];    // computed, waiting for downstream
   logic [WIDTH-1:0]  got_q[$];    // results the DUT actually delivered
   int unsigned       got_cyc[$];  // cycle each delivery happened
   logic [WIDTH-1:0]  m_acc;
   logic [CNT_W-1:0]  m_cnt;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [WIDTH-1:0] ref_op(input logic [1:0] o,
                                               input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
      case (o)
         2'd0:    return x & y;
         2'd1:    return x | y;
         2'd2:    return x ^ y;
         default: return ~(x & y);
      endcase
   endfunction

   // ---------------- model + compare, once per cycle ----------------
   always @(negedge clk) begin
      if (!rst_n) begin
         pend_q.delete();
         exp_q.delete();
         m_acc = '0;
         m_cnt = '0;
         check("rst_out_valid", out_valid, 0);
         check("rst_in_ready", in_ready, 1);
         check("rst_result", result, 0);
         check("rst_txn_count", txn_count, 0);
      end else begin
         bit               m_ov;
         bit               m_stall;
         bit               m_ir;
         beat_t            bt;
         logic [WIDTH-1:0] r;
         m_ov    = exp_q.size() > 0;
         m_stall = m_ov && !out_ready;
         m_ir    = !(pend_q.size() > 0 && m_stall);
         check("out_valid", out_valid, m_ov);
         check("in_ready", in_ready, m_ir);
         check("txn_count", txn_count, m_cnt);
         if (m_ov) check("result", result, exp_q[0]);
         if (out_valid && out_ready) begin
            got_q.push_back(result);
            got_cyc.push_back(cyc);
         end
         // advance the model across the coming edge
         if (m_ov && out_ready) begin
            void'(exp_q.pop_front());
            m_cnt = m_cnt + 1'b1;
         end
         if (!m_stall && pend_q.size() > 0) begin
            bt = pend_q.pop_front();
            r  = ref_op(bt.op, bt.acc_en ? m_acc : bt.a, bt.b);
            exp_q.push_back(r);
            if (bt.acc_en) m_acc = r;
         end
         if (acc_clr) m_acc = '0;
         if (in_valid && m_ir) begin
            bt.op = op; bt.acc_en = acc_en; bt.a = a; bt.b = b;
            pend_q.push_back(bt);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic idle();
      in_valid = 1'b0;
      acc_en   = 1'b0;
      acc_clr  = 1'b0;
   endtask

   task automatic do_reset();
      @(posedge clk); #2;
      idle();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      out_ready = 1'b1;
      rst_n = 1'b1;
      got_q.delete();
      got_cyc.delete();
   endtask

   // Present one beat and hold it until it transfers (bounded wait).
   task automatic send_beat(input logic [1:0] o, input logic ae,
                            input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
      int n;
      @(posedge clk); #1;
      in_valid = 1'b1; op = o; acc_en = ae; a = av; b = bv;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         total++;
         bad++;
         $display("FAIL send_timeout: in_ready stuck low for %0d cycles", n);
      end
      @(posedge clk); #1;
      idle();
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #1500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   logic [WIDTH-1:0] lit_op [4]  = '{8'h30, 8'hFC, 8'hCC, 8'hCF};
   logic [WIDTH-1:0] lit_xor[4]  = '{8'hFE, 8'hFD, 8'hFC, 8'hFB};
   logic [WIDTH-1:0] lit_acc[4]  = '{8'h01, 8'h03, 8'h07, 8'h10};
   logic [WIDTH-1:0] acc_b  [3]  = '{8'h01, 8'h02, 8'h04};

   initial begin
      int k;
      bit ok;
      rst_n = 1'b0; out_ready = 1'b1;
      op = 2'd0; a = '0; b = '0;
      idle();
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // single beats, each op, two-cycle latency
      for (int i = 0; i < 4; i++) begin
         send_beat(2'(i), 1'b0, 8'hF0, 8'h3C);
         @(posedge clk); #1;
         check("op_latency_valid", out_valid, 1);
         check("op_literal", result, lit_op[i]);
      end

      // four back-to-back XOR beats
      do_reset();
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         in_valid = 1'b1; op = OP_XOR; a = 8'(i + 1); b = 8'hFF;
      end
      @(posedge clk); #1;
      idle();
      repeat (3) @(posedge clk);
      #1;
      check("b2b_count", got_q.size(), 4);
      for (int i = 0; i < 4 && i < got_q.size(); i++) check("b2b_result", got_q[i], lit_xor[i]);
      for (int i = 0; i < 3 && i + 1 < got_cyc.size(); i++)
         check("b2b_consecutive", got_cyc[i + 1] - got_cyc[i], 1);
      check("b2b_txn_count", txn_count, 4);

      // five-cycle backpressure while streaming
      do_reset();
      out_ready = 1'b0;
      k = 0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         if (c == 5) out_ready = 1'b1;
         in_valid = (k < 6); op = OP_XOR; a = 8'(k); b = 8'h80;
         @(negedge clk);
         if (c == 2) begin
            check("stall_accepted", k, 2);
            check("stall_in_ready", in_ready, 0);
         end
         if (c == 4) begin
            check("stall_valid_held", out_valid, 1);
            check("stall_result_held", result, 8'h80);
         end
         if (in_valid && in_ready) k++;
      end
      idle();
      repeat (4) @(posedge clk);
      #1;
      check("stall_count", got_q.size(), 6);
      for (int i = 0; i < 6 && i < got_q.size(); i++) check("stall_order", got_q[i], 8'(i) ^ 8'h80);

      // accumulate chain, then clear
      do_reset();
      @(posedge clk); #1 acc_clr = 1'b1;
      @(posedge clk); #1 acc_clr = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; op = OP_OR; acc_en = 1'b1; a = 8'hFF; b = acc_b[i];
         @(posedge clk); #1;
      end
      idle();
      repeat (3) @(posedge clk);
      #1 acc_clr = 1'b1;
      @(posedge clk); #1 acc_clr = 1'b0;
      send_beat(OP_OR, 1'b1, 8'hFF, 8'h10);
      repeat (3) @(posedge clk);
      #1;
      check("acc_count", got_q.size(), 4);
      for (int i = 0; i < 4 && i < got_q.size(); i++) check("acc_result", got_q[i], lit_acc[i]);

      // asynchronous reset in the middle of a stall
      do_reset();
      send_beat(OP_OR, 1'b1, 8'h00, 8'h0F);
      repeat (3) @(posedge clk);
      #1 out_ready = 1'b0;
      in_valid = 1'b1; op = OP_AND; a = 8'h12; b = 8'hFF;
      @(posedge clk); #1 a = 8'h34;
      @(posedge clk); #1 idle();
      @(posedge clk); #1;
      check("pre_rst_out_valid", out_valid, 1);
      check("pre_rst_in_ready", in_ready, 0);
      check("pre_rst_txn_count", txn_count, 1);
      #1 rst_n = 1'b0;
      #1;
      check("async_rst_out_valid", out_valid, 0);
      check("async_rst_txn_count", txn_count, 0);
      check("async_rst_in_ready", in_ready, 1);
      repeat (2) @(posedge clk);
      #1 out_ready = 1'b1; rst_n = 1'b1;
      got_q.delete();
      send_beat(OP_OR, 1'b0, 8'hAA, 8'h55);
      send_beat(OP_OR, 1'b1, 8'hFF, 8'h00);
      repeat (3) @(posedge clk);
      #1;
      check("post_rst_count", got_q.size(), 2);
      if (got_q.size() >= 2) begin
         check("post_rst_or", got_q[0], 8'hFF);
         check("post_rst_acc_zero", got_q[1], 8'h00);
      end

      // randomized traffic with backpressure and clears
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk); #1;
         if (!in_valid || ok) begin
            in_valid = ($urandom_range(0, 3) != 0);
            op       = 2'($urandom_range(0, 3));
            acc_en   = 1'($urandom_range(0, 1));
            a        = 8'($urandom);
            b        = 8'($urandom);
         end
         acc_clr   = ($urandom_range(0, 7) == 0);
         out_ready = ($urandom_range(0, 3) != 0);
      end
      @(negedge clk);
      ok = in_ready;
      while (!ok) begin
         @(negedge clk);
         ok = in_ready;
      end
      @(posedge clk); #1;
      idle();
      out_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("rand_drained", out_valid, 0);

      // counter wrap
      do_reset();
      in_valid = 1'b1; acc_en = 1'b0;
      for (int i = 0; i < 65535; i++) begin
         op = 2'($urandom_range(0, 3));
         a  = 8'($urandom);
         b  = 8'($urandom);
         @(posedge clk); #1;
      end
      idle();
      repeat (3) @(posedge clk);
      #1;
      check("wrap_full", txn_count, 16'hFFFF);
      got_q.delete();
      got_cyc.delete();
      send_beat(OP_AND, 1'b0, 8'hFF, 8'hFF);
      repeat (3) @(posedge clk);
      #1;
      check("wrap_zero", txn_count, 16'h0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
